// File: rtl/unsigned_divider_shift_sub_8x4.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Optional debug ports DBG_STATE / DBG_REM are enabled by defining UNSIGNED_DIVIDER_DEBUG_EN.
module unsigned_divider_shift_sub_8x4 #(
    parameter int N = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2*N-1:0]   DIVIDEND,
    input  logic [N-1:0]     DIVISOR,
    output logic             BUSY,
    output logic             DONE,
    output logic [N-1:0]     QUOTIENT,
    output logic [N-1:0]     REMAINDER,
    output logic             DIV_ERR
`ifdef UNSIGNED_DIVIDER_DEBUG_EN
    ,
    output logic [1:0]       DBG_STATE,
    output logic [N:0]       DBG_REM
`endif
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [N:0]      r_rem, w_rem_nxt;
    logic [N-1:0]    r_qsh, w_qsh_nxt;
    logic [N-1:0]    r_dsr, w_dsr_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_err, w_err_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_done, w_done_nxt;
    logic [N-1:0]    r_quo, w_quo_nxt;
    logic [N-1:0]    r_remo, w_remo_nxt;
    logic            r_derr, w_derr_nxt;

    logic [N:0]      w_sh_rem;
    logic [N-1:0]    w_sh_q;
    logic [N+1:0]    w_diff;
    logic            w_fits;
    logic            w_ovf;

    // R stays below the divisor between steps, so its top bit is always 0 before the shift.
    assign w_sh_rem = {r_rem[N-1:0], r_qsh[N-1]};
    assign w_sh_q   = r_qsh << 1;
    assign w_diff   = {1'b0, w_sh_rem} - {2'b00, r_dsr};
    assign w_fits   = ~w_diff[N+1];
    assign w_ovf    = (DIVIDEND[2*N-1:N] >= DIVISOR);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_qsh_nxt   = r_qsh;
        w_dsr_nxt   = r_dsr;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_quo_nxt   = r_quo;
        w_remo_nxt  = r_remo;
        w_derr_nxt  = r_derr;
        case (r_state)
            S_IDLE: begin
                // BUSY is held through the DONE cycle and drops on the next edge unless re-accepted.
                w_busy_nxt = START;
                if (START) begin
                    w_dsr_nxt = DIVISOR;
                    if (w_ovf) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_FIN;
                    end else begin
                        w_err_nxt   = 1'b0;
                        w_rem_nxt   = {1'b0, DIVIDEND[2*N-1:N]};
                        w_qsh_nxt   = DIVIDEND[N-1:0];
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                w_rem_nxt = w_fits ? w_diff[N:0] : w_sh_rem;
                w_qsh_nxt = {w_sh_q[N-1:1], w_fits};
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == CW'(N - 1)) w_state_nxt = S_FIN;
            end
            S_FIN: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
                if (r_err) begin
                    w_quo_nxt  = '1;
                    w_remo_nxt = '0;
                    w_derr_nxt = 1'b1;
                end else begin
                    w_quo_nxt  = r_qsh;
                    w_remo_nxt = r_rem[N-1:0];
                    w_derr_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rem  <= '0;
            r_qsh  <= '0;
            r_dsr  <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_quo  <= '0;
            r_remo <= '0;
            r_derr <= 1'b0;
        end else begin
            r_rem  <= w_rem_nxt;
            r_qsh  <= w_qsh_nxt;
            r_dsr  <= w_dsr_nxt;
            r_cnt  <= w_cnt_nxt;
            r_err  <= w_err_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_quo  <= w_quo_nxt;
            r_remo <= w_remo_nxt;
            r_derr <= w_derr_nxt;
        end
    end

    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign QUOTIENT  = r_quo;
    assign REMAINDER = r_remo;
    assign DIV_ERR   = r_derr;

`ifdef UNSIGNED_DIVIDER_DEBUG_EN
    assign DBG_STATE = r_state;
    assign DBG_REM   = r_rem;
`endif

endmodule

// File: tb/tb_unsigned_divider_shift_sub_8x4.sv
// Directed self-checking bench for unsigned_divider_shift_sub_8x4 (N=4).
module tb_unsigned_divider_shift_sub_8x4;

    localparam int N = 4;

    logic           CLK;
    logic           RESET;
    logic           START;
    logic [2*N-1:0] DIVIDEND;
    logic [N-1:0]   DIVISOR;
    logic           BUSY;
    logic           DONE;
    logic [N-1:0]   QUOTIENT;
    logic [N-1:0]   REMAINDER;
    logic           DIV_ERR;
`ifdef UNSIGNED_DIVIDER_DEBUG_EN
    logic [1:0]     DBG_STATE;
    logic [N:0]     DBG_REM;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;
    bit dbg_on  = 0;
    logic [1:0] exp_st [0:12] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0,
                                  2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0};

    unsigned_divider_shift_sub_8x4 #(.N(N)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .DIVIDEND  (DIVIDEND),
        .DIVISOR   (DIVISOR),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .QUOTIENT  (QUOTIENT),
        .REMAINDER (REMAINDER),
        .DIV_ERR   (DIV_ERR)
`ifdef UNSIGNED_DIVIDER_DEBUG_EN
        ,
        .DBG_STATE (DBG_STATE),
        .DBG_REM   (DBG_REM)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        edge_n++;
`ifdef UNSIGNED_DIVIDER_DEBUG_EN
        if (dbg_on && edge_n >= 0 && edge_n <= 12)
            check($sformatf("dbg_state_e%0d", edge_n), 32'(DBG_STATE), 32'(exp_st[edge_n]));
`endif
    endtask

    // Drives one START cycle; returns just after the accepting edge (edge_n = 0).
    task automatic start_op(input logic [7:0] dd, input logic [3:0] ds, input string tag);
        START    = 1'b1;
        DIVIDEND = dd;
        DIVISOR  = ds;
        edge_n   = -1;
        tick();
        START    = 1'b0;
        DIVIDEND = ~dd;
        DIVISOR  = ~ds;
        check({tag, "_busy_acc"}, 32'(BUSY), 32'd1);
    endtask

    task automatic wait_done(input int lat, input logic [3:0] q, input logic [3:0] r,
                             input logic err, input bit drop, input string tag);
        while (DONE !== 1'b1 && edge_n < 30) begin
            tick();
            if (DONE !== 1'b1) check({tag, "_busy_run"}, 32'(BUSY), 32'd1);
        end
        check({tag, "_latency"}, 32'(edge_n), 32'(lat));
        check({tag, "_q"},   32'(QUOTIENT),  32'(q));
        check({tag, "_r"},   32'(REMAINDER), 32'(r));
        check({tag, "_err"}, 32'(DIV_ERR),   32'(err));
        check({tag, "_busy_done"}, 32'(BUSY), 32'd1);
        if (drop) begin
            tick();
            check({tag, "_done_drop"}, 32'(DONE), 32'd0);
            check({tag, "_busy_drop"}, 32'(BUSY), 32'd0);
            check({tag, "_q_hold"},    32'(QUOTIENT), 32'(q));
        end
    endtask

    task automatic do_div(input logic [7:0] dd, input logic [3:0] ds, input logic [3:0] q,
                          input logic [3:0] r, input logic err, input string tag);
        start_op(dd, ds, tag);
        wait_done(err ? 1 : N + 1, q, r, err, 1'b1, tag);
    endtask

    initial begin
        RESET    = 1'b0;
        START    = 1'b0;
        DIVIDEND = '0;
        DIVISOR  = '0;
        #1;
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_q",    32'(QUOTIENT), 32'd0);
        check("rst_r",    32'(REMAINDER), 32'd0);
        check("rst_err",  32'(DIV_ERR), 32'd0);
`ifdef UNSIGNED_DIVIDER_DEBUG_EN
        check("rst_dbg_state", 32'(DBG_STATE), 32'd0);
        check("rst_dbg_rem",   32'(DBG_REM), 32'd0);
`endif
        #7 RESET = 1'b1;
        @(posedge CLK);
        #1;

        do_div(8'd100, 4'd7,  4'd14, 4'd2, 1'b0, "d100_7");
        do_div(8'd225, 4'd15, 4'd15, 4'd0, 1'b0, "d225_15");
        do_div(8'd64,  4'd4,  4'hF,  4'd0, 1'b1, "ovf64_4");
        do_div(8'd9,   4'd0,  4'hF,  4'd0, 1'b1, "dz9_0");

        // Second START during a run must be ignored.
        start_op(8'd100, 4'd7, "ign");
        tick();
        START = 1'b1; DIVIDEND = 8'd200; DIVISOR = 4'd13;
        tick();
        START = 1'b0;
        wait_done(N + 1, 4'd14, 4'd2, 1'b0, 1'b1, "ign");

        // Asynchronous reset at edge 3 of a run.
        start_op(8'd100, 4'd7, "rst_mid");
        tick();
        tick();
        @(posedge CLK);
        RESET = 1'b0;
        #1;
        check("rst_mid_busy", 32'(BUSY), 32'd0);
        check("rst_mid_done", 32'(DONE), 32'd0);
        check("rst_mid_q",    32'(QUOTIENT), 32'd0);
        check("rst_mid_r",    32'(REMAINDER), 32'd0);
        check("rst_mid_err",  32'(DIV_ERR), 32'd0);
        tick();
        RESET = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rst_mid_no_done", 32'(DONE), 32'd0);
        end
        do_div(8'd50, 4'd6, 4'd8, 4'd2, 1'b0, "d50_6");

        // START held high across two operations.
        START = 1'b1; DIVIDEND = 8'd100; DIVISOR = 4'd7;
        edge_n = -1;
        dbg_on = 1'b1;
        tick();
        DIVIDEND = 8'd200; DIVISOR = 4'd13;
        wait_done(N + 1, 4'd14, 4'd2, 1'b0, 1'b0, "b2b1");
        tick();
        check("b2b_done_gap", 32'(DONE), 32'd0);
        check("b2b_busy_gap", 32'(BUSY), 32'd1);
        START = 1'b0;
        DIVIDEND = 8'd0; DIVISOR = 4'd0;
        wait_done(2 * N + 3, 4'd15, 4'd5, 1'b0, 1'b1, "b2b2");
        dbg_on = 1'b0;

        // Every product of two 4-bit factors divided by one factor gives the other back.
        for (int a = 1; a <= 15; a++) begin
            for (int b = 1; b <= 15; b++) begin
                do_div(8'(a * b), 4'(b), 4'(a), 4'd0, 1'b0, $sformatf("sweep_%0dx%0d", a, b));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
